// File: rtl/jt900h_alu_ctl_if.sv
// Command handshake between the instruction decoder and the ALU sequencer.
// The decoder holds req and the cmd_* fields until ready is seen high.
interface jt900h_alu_ctl_if;
    logic        req;
    logic        ready;
    logic [5:0]  cmd_sel;
    logic [2:0]  cmd_w;
    logic [7:0]  cmd_srca;
    logic [7:0]  cmd_srcb;
    logic [7:0]  cmd_dst;
    logic [31:0] cmd_imm;
    logic        cmd_useimm;
    logic        cmd_wb;
    logic        cmd_updf;

    modport master (
        output req, cmd_sel, cmd_w, cmd_srca, cmd_srcb,
        output cmd_dst, cmd_imm, cmd_useimm, cmd_wb, cmd_updf,
        input  ready
    );

    modport slave (
        input  req, cmd_sel, cmd_w, cmd_srca, cmd_srcb,
        input  cmd_dst, cmd_imm, cmd_useimm, cmd_wb, cmd_updf,
        output ready
    );
endinterface

// File: rtl/jt900h_alu_ctl.sv
// ALU sequencer: reads operands from the register file, fires the ALU
// for one cycle, then writes the result back and updates the F register.
module jt900h_alu_ctl #(
    parameter logic [7:0] FRST = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    jt900h_alu_ctl_if.slave      cmd,
    output logic [7:0]           rf_addr,
    input  logic [31:0]          rf_rdata,
    output logic                 rf_we,
    output logic [7:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [3:0]           rf_wmask,
    output logic [31:0]          alu_op0,
    output logic [31:0]          alu_op1,
    output logic [31:0]          alu_imm,
    output logic                 alu_opmux,
    output logic [2:0]           alu_w,
    output logic [5:0]           alu_sel,
    output logic                 alu_cen,
    input  logic [31:0]          alu_dout,
    input  logic [7:0]           alu_flags,
    output logic [7:0]           flags,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        EXE,
        WB
    } state_t;

    state_t      state;
    state_t      nxt;

    logic [5:0]  sel_r;
    logic [2:0]  w_r;
    logic [7:0]  srca_r;
    logic [7:0]  srcb_r;
    logic [7:0]  dst_r;
    logic [31:0] imm_r;
    logic        useimm_r;
    logic        wb_r;
    logic        updf_r;

    logic [31:0] op0_r;
    logic [31:0] op0_hold;
    logic [31:0] op1_hold;
    logic [31:0] op0_live;
    logic [31:0] op1_live;
    logic        accept;

    assign accept = cmd.req & cmd.ready;

    // With an immediate the A read lands directly in EXE, bypassing op0_r
    assign op0_live = useimm_r ? rf_rdata : op0_r;
    assign op1_live = useimm_r ? imm_r    : rf_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel_r    <= '0;
            w_r      <= '0;
            srca_r   <= '0;
            srcb_r   <= '0;
            dst_r    <= '0;
            imm_r    <= '0;
            useimm_r <= 1'b0;
            wb_r     <= 1'b0;
            updf_r   <= 1'b0;
            op0_r    <= '0;
            op0_hold <= '0;
            op1_hold <= '0;
            flags    <= FRST;
        end else begin
            state <= nxt;
            if (accept) begin
                sel_r    <= cmd.cmd_sel;
                w_r      <= cmd.cmd_w;
                srca_r   <= cmd.cmd_srca;
                srcb_r   <= cmd.cmd_srcb;
                dst_r    <= cmd.cmd_dst;
                imm_r    <= cmd.cmd_imm;
                useimm_r <= cmd.cmd_useimm;
                wb_r     <= cmd.cmd_wb;
                updf_r   <= cmd.cmd_updf;
            end
            if (state == RDB) begin
                op0_r <= rf_rdata;
            end
            if (state == EXE) begin
                op0_hold <= op0_live;
                op1_hold <= op1_live;
            end
            if (state == WB && updf_r) begin
                flags <= alu_flags;
            end
        end
    end

    always_comb begin
        nxt       = state;
        cmd.ready = 1'b0;
        rf_addr   = 8'h00;
        alu_cen   = 1'b0;
        rf_we     = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd.ready = 1'b1;
                if (cmd.req) begin
                    nxt = RDA;
                end
            end
            RDA: begin
                rf_addr = srca_r;
                nxt     = useimm_r ? EXE : RDB;
            end
            RDB: begin
                rf_addr = srcb_r;
                nxt     = EXE;
            end
            EXE: begin
                alu_cen = 1'b1;
                nxt     = WB;
            end
            WB: begin
                done  = 1'b1;
                rf_we = wb_r;
                nxt   = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Byte beats word beats long, so multi-hot and zero widths still decode
    always_comb begin
        rf_wmask = 4'b1111;
        priority case (1'b1)
            w_r[0]:  rf_wmask = 4'b0001;
            w_r[1]:  rf_wmask = 4'b0011;
            default: rf_wmask = 4'b1111;
        endcase
    end

    assign rf_waddr  = dst_r;
    assign rf_wdata  = alu_dout;

    assign alu_op0   = (state == EXE) ? op0_live : op0_hold;
    assign alu_op1   = (state == EXE) ? op1_live : op1_hold;
    assign alu_imm   = imm_r;
    assign alu_opmux = useimm_r;
    assign alu_w     = w_r;
    assign alu_sel   = sel_r;

endmodule

// File: doc/jt900h_alu_ctl.md
Name: jt900h_alu_ctl

Overview:
- Sequencer on the driving side of the ALU.
- Accepts one decoded ALU command from the instruction decoder over a req/ready handshake.
- Reads operands from the register file (1-cycle read latency), presents them to the ALU, and pulses its cen.
- Writes the registered ALU result back with a width-based byte mask and updates the architectural F flag register.

Parameters:
- FRST, 8'h00, reset value of the F flag register.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req  in  1  command valid
- ready  out  1  high only in IDLE; transfer when req&ready
- cmd_sel  in  6  ALU operation code (jt900h.inc ALU_* values)
- cmd_w  in  3  width, one-hot: [0] byte, [1] word, [2] long
- cmd_srca  in  8  register address of op0
- cmd_srcb  in  8  register address of op1 (ignored if cmd_useimm)
- cmd_dst  in  8  write-back register address
- cmd_imm  in  32  immediate
- cmd_useimm  in  1  op1/op2 from immediate; skip operand B read
- cmd_wb  in  1  write result back (0 for compare-type ops)
- cmd_updf  in  1  load F from ALU flags
- rf_addr  out  8  register file read address
- rf_rdata  in  32  read data, valid the cycle after rf_addr
- rf_we  out  1  register write strobe
- rf_waddr  out  8  write address
- rf_wdata  out  32  write data
- rf_wmask  out  4  byte enables
- alu_op0, alu_op1, alu_imm  out  32 each  ALU operands
- alu_opmux  out  1  ALU immediate select
- alu_w  out  3  ALU width
- alu_sel  out  6  ALU operation
- alu_cen  out  1  ALU clock enable
- alu_dout  in  32  registered ALU result
- alu_flags  in  8  registered ALU flags {S,Z,0,H,0,V,N,C}
- flags  out  8  F register
- done  out  1  1-cycle pulse in WB

Behaviour:
- Reset (async, rst=0): state IDLE; ready=1; rf_we=0; alu_cen=0; done=0; flags=FRST; all latched command and operand registers 0. Asserting reset mid-command aborts it with no register write and no flag update.
- Accept at clock edge with req&ready: latch all cmd_* fields. Cycle numbering below is relative to that edge (c0).
- FSM states: IDLE, RDA, RDB, EXE, WB.
- IDLE: ready=1; rf_addr=0. On accept go to RDA.
- RDA (c1): rf_addr=srca. Next state RDB, or EXE when useimm.
- RDB (c2): capture rf_rdata into op0_r; rf_addr=srcb. Next state EXE.
- EXE (c2 with imm, c3 without): alu_cen=1 for exactly this cycle.
  - With useimm: alu_op0=rf_rdata, alu_op1=imm.
  - Without useimm: alu_op0=op0_r, alu_op1=rf_rdata.
  - alu_imm=imm; alu_opmux=useimm; alu_sel and alu_w from the latched command.
  - Next state WB.
- WB (c3 with imm, c4 without): done=1.
  - If wb: rf_we=1, rf_waddr=dst, rf_wdata=alu_dout.
  - If updf: flags<=alu_flags at end of cycle.
  - Next state IDLE; ready=1 the following cycle.
- Throughput: one command per 5 cycles (4 with immediate). req while ready=0 is ignored; it must be held until accepted.
- Outside EXE: alu_cen=0; ALU operand outputs hold their last values.
- Width decode, priority as in the ALU: w[0] → mask 4'b0001; else w[1] → 4'b0011; else → 4'b1111. w=0 or multi-hot follows this priority.
- rf_wdata carries the full 32-bit result; rf_wmask alone limits the write.
- No read/write hazard: WB and RDA never coincide. A command sourcing the previous dst reads the updated value.
- updf=0 leaves flags unchanged even though the ALU flags change.

Test Plan:
- Reset: drop rst asynchronously mid-RDB → ready=1, rf_we=0, flags=FRST immediately; no write afterwards.
- Byte ADD: srca=0xE0 holding 0x00000012, srcb=0xE4 holding 0x00000034, w=001, wb=1, updf=1 → done and rf_we at c4; rf_waddr=dst; rf_wdata[7:0]=0x46; rf_wmask=0001; flags S=0 Z=0 C=0.
- Immediate long ADD: srca holds 0xFFFFFFFF, imm=1, useimm=1, w=100 → alu_opmux=1; WB at c3; rf_wdata=0; mask=1111; Z=1, C=1.
- Compare-type: wb=0, updf=1 → no rf_we; flags updated at WB; next command accepted at c5.
- Back-to-back: req held high for two commands, second sources the first's dst → ready low c1–c4, second accepted at c5, second RDA reads the updated value.
- Word width with w=011 → mask 0001 (byte priority); w=000 → mask 1111.
